// File: rtl/phase_sequencer.sv
// phase_sequencer: multi-cycle core phase controller.
// Steps the core through FETCH, DECODE, EXECUTE, MEMORYACCESS and WRITEBACK.
// It holds a phase while that phase's own unit stalls, and parks in HALT at an
// instruction boundary. It also keeps the cycle and retired-instruction counters.
module phase_sequencer #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_fetch,
    input  logic                 stall_execute,
    input  logic                 stall_memoryaccess,
    input  logic                 halt_req,
    output logic                 phase_fetch,
    output logic                 phase_decode,
    output logic                 phase_execute,
    output logic                 phase_memoryaccess,
    output logic                 phase_writeback,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        FETCH        = 3'd1,
        DECODE       = 3'd2,
        EXECUTE      = 3'd3,
        MEMORYACCESS = 3'd4,
        WRITEBACK    = 3'd5,
        HALT         = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    // Next phase: each stall is honoured only in its own phase, halt only at the boundary
    always_comb begin
        state_next = state;
        case (state)
            IDLE:         state_next = FETCH;
            FETCH:        state_next = stall_fetch ? FETCH : DECODE;
            DECODE:       state_next = EXECUTE;
            EXECUTE:      state_next = stall_execute ? EXECUTE : MEMORYACCESS;
            MEMORYACCESS: state_next = stall_memoryaccess ? MEMORYACCESS : WRITEBACK;
            WRITEBACK:    state_next = halt_req ? HALT : FETCH;
            HALT:         state_next = halt_req ? HALT : FETCH;
            default:      state_next = IDLE;
        endcase
    end

    // State register, registered strobes decoded from the next state, and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            phase_fetch        <= 1'b0;
            phase_decode       <= 1'b0;
            phase_execute      <= 1'b0;
            phase_memoryaccess <= 1'b0;
            phase_writeback    <= 1'b0;
            halted             <= 1'b0;
            cycle_count        <= '0;
            instret_count      <= '0;
        end else begin
            state              <= state_next;
            phase_fetch        <= (state_next == FETCH);
            phase_decode       <= (state_next == DECODE);
            phase_execute      <= (state_next == EXECUTE);
            phase_memoryaccess <= (state_next == MEMORYACCESS);
            phase_writeback    <= (state_next == WRITEBACK);
            halted             <= (state_next == HALT);
            if (state != IDLE && state != HALT) begin
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            end
            if (state == WRITEBACK) begin
                instret_count <= instret_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed, table-driven check of phase_sequencer.
// A 64-bit instance carries the main vector table; a 4-bit-counter instance
// shares the same inputs and is checked for counter wrap.
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_fetch = 1'b0;
    logic stall_execute = 1'b0;
    logic stall_memoryaccess = 1'b0;
    logic halt_req = 1'b0;

    logic        pf, pd, pe, pm, pw, halted;
    logic [63:0] cycle_count, instret_count;
    logic        npf, npd, npe, npm, npw, nhalted;
    logic [3:0]  ncycle, ninstret;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_F    = 5'b10000;
    localparam logic [4:0] P_D    = 5'b01000;
    localparam logic [4:0] P_E    = 5'b00100;
    localparam logic [4:0] P_M    = 5'b00010;
    localparam logic [4:0] P_W    = 5'b00001;

    typedef struct {
        logic        r;
        logic        sf;
        logic        se;
        logic        sm;
        logic        h;
        logic [4:0]  ph;
        logic        hl;
        logic [63:0] cyc;
        logic [63:0] ins;
    } vec_t;

    vec_t vecs[$];

    phase_sequencer #(.CNT_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .stall_fetch(stall_fetch), .stall_execute(stall_execute),
        .stall_memoryaccess(stall_memoryaccess), .halt_req(halt_req),
        .phase_fetch(pf), .phase_decode(pd), .phase_execute(pe),
        .phase_memoryaccess(pm), .phase_writeback(pw), .halted(halted),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    phase_sequencer #(.CNT_WIDTH(4)) dut_narrow (
        .clk(clk), .rst(rst),
        .stall_fetch(stall_fetch), .stall_execute(stall_execute),
        .stall_memoryaccess(stall_memoryaccess), .halt_req(halt_req),
        .phase_fetch(npf), .phase_decode(npd), .phase_execute(npe),
        .phase_memoryaccess(npm), .phase_writeback(npw), .halted(nhalted),
        .cycle_count(ncycle), .instret_count(ninstret)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic sf, logic se, logic sm, logic h,
                                logic [4:0] ph, logic hl, int cyc, int ins);
        vec_t v;
        v.r = r; v.sf = sf; v.se = se; v.sm = sm; v.h = h;
        v.ph = ph; v.hl = hl; v.cyc = 64'(cyc); v.ins = 64'(ins);
        return v;
    endfunction

    // Drive inputs at the falling edge, then let one rising edge pass and settle
    task automatic applyStimulus(input logic r, input logic sf, input logic se,
                                 input logic sm, input logic h);
        @(negedge clk);
        rst = r;
        stall_fetch = sf;
        stall_execute = se;
        stall_memoryaccess = sm;
        halt_req = h;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Reset release, then three unstalled instructions
        vecs.push_back(mk(1,0,0,0,0, P_NONE,0, 0,0));
        vecs.push_back(mk(1,0,0,0,0, P_NONE,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 1,0));
        vecs.push_back(mk(0,0,0,0,0, P_E,0, 2,0));
        vecs.push_back(mk(0,0,0,0,0, P_M,0, 3,0));
        vecs.push_back(mk(0,0,0,0,0, P_W,0, 4,0));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 5,1));
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 6,1));
        vecs.push_back(mk(0,0,0,0,0, P_E,0, 7,1));
        vecs.push_back(mk(0,0,0,0,0, P_M,0, 8,1));
        vecs.push_back(mk(0,0,0,0,0, P_W,0, 9,1));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 10,2));
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 11,2));
        vecs.push_back(mk(0,0,0,0,0, P_E,0, 12,2));
        vecs.push_back(mk(0,0,0,0,0, P_M,0, 13,2));
        vecs.push_back(mk(0,0,0,0,0, P_W,0, 14,2));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 15,3));
        // Execute stall held for 3 edges
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 16,3));
        vecs.push_back(mk(0,0,0,0,0, P_E,0, 17,3));
        vecs.push_back(mk(0,0,1,0,0, P_E,0, 18,3));
        vecs.push_back(mk(0,0,1,0,0, P_E,0, 19,3));
        vecs.push_back(mk(0,0,1,0,0, P_E,0, 20,3));
        vecs.push_back(mk(0,0,0,0,0, P_M,0, 21,3));
        vecs.push_back(mk(0,0,0,0,0, P_W,0, 22,3));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 23,4));
        // Fetch stall during decode and execute has no effect
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 24,4));
        vecs.push_back(mk(0,1,0,0,0, P_E,0, 25,4));
        vecs.push_back(mk(0,1,0,0,0, P_M,0, 26,4));
        vecs.push_back(mk(0,0,0,0,0, P_W,0, 27,4));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 28,5));
        // Foreign stalls ignored, memory stall honoured, stalls irrelevant in writeback
        vecs.push_back(mk(0,0,1,1,0, P_D,0, 29,5));
        vecs.push_back(mk(0,0,0,0,0, P_E,0, 30,5));
        vecs.push_back(mk(0,0,0,1,0, P_M,0, 31,5));
        vecs.push_back(mk(0,0,0,1,0, P_M,0, 32,5));
        vecs.push_back(mk(0,0,0,0,0, P_W,0, 33,5));
        vecs.push_back(mk(0,1,1,1,0, P_F,0, 34,6));
        // Halt raised during execute: instruction completes, counters freeze
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 35,6));
        vecs.push_back(mk(0,0,0,0,0, P_E,0, 36,6));
        vecs.push_back(mk(0,0,0,0,1, P_M,0, 37,6));
        vecs.push_back(mk(0,0,0,0,1, P_W,0, 38,6));
        vecs.push_back(mk(0,0,0,0,1, P_NONE,1, 39,7));
        vecs.push_back(mk(0,0,0,0,1, P_NONE,1, 39,7));
        vecs.push_back(mk(0,0,0,0,1, P_NONE,1, 39,7));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 39,7));
        // Reset while stalled in memory access, then fetch stall honoured
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 40,7));
        vecs.push_back(mk(0,0,0,0,0, P_E,0, 41,7));
        vecs.push_back(mk(0,0,0,0,0, P_M,0, 42,7));
        vecs.push_back(mk(0,0,0,1,0, P_M,0, 43,7));
        vecs.push_back(mk(1,0,0,1,0, P_NONE,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0, P_F,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0, P_F,0, 1,0));
        vecs.push_back(mk(0,0,0,0,0, P_D,0, 2,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].sf, vecs[i].se, vecs[i].sm, vecs[i].h);
            checkOutput($sformatf("phases[%0d]", i), 64'({pf, pd, pe, pm, pw}), 64'(vecs[i].ph));
            checkOutput($sformatf("halted[%0d]", i), 64'(halted), 64'(vecs[i].hl));
            checkOutput($sformatf("cycle_count[%0d]", i), cycle_count, vecs[i].cyc);
            checkOutput($sformatf("instret_count[%0d]", i), instret_count, vecs[i].ins);
        end

        // Counter wrap on the 4-bit instance: reset, release, then 20 unstalled cycles
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("narrow_release_cycle", 64'(ncycle), 64'd0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("narrow_cycle_20", 64'(ncycle), 64'd4);
        checkOutput("narrow_instret_4", 64'(ninstret), 64'd4);
        checkOutput("narrow_phase_fetch", 64'(npf), 64'd1);
        for (int i = 0; i < 60; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("narrow_cycle_80", 64'(ncycle), 64'd0);
        checkOutput("narrow_instret_16", 64'(ninstret), 64'd0);
        checkOutput("wide_cycle_80", cycle_count, 64'd80);
        checkOutput("wide_instret_16", instret_count, 64'd16);

        // Halt requested from FETCH: park after this instruction, bounded wait
        begin
            int waited;
            waited = 0;
            applyStimulus(0, 0, 0, 0, 1);
            while (!halted && waited < 10) begin
                applyStimulus(0, 0, 0, 0, 1);
                waited++;
            end
            checkOutput("halt_wait_edges", 64'(waited), 64'd4);
        end
        checkOutput("halt_wide_cycle", cycle_count, 64'd85);
        checkOutput("halt_wide_instret", instret_count, 64'd17);
        checkOutput("halt_narrow_cycle", 64'(ncycle), 64'd5);
        checkOutput("halt_narrow_instret", 64'(ninstret), 64'd1);
        checkOutput("halt_phases", 64'({pf, pd, pe, pm, pw}), 64'(P_NONE));

        // Reset while parked in HALT
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("rst_in_halt_halted", 64'(halted), 64'd0);
        checkOutput("rst_in_halt_cycle", cycle_count, 64'd0);
        checkOutput("rst_in_halt_instret", instret_count, 64'd0);
        checkOutput("rst_in_halt_phases", 64'({pf, pd, pe, pm, pw}), 64'(P_NONE));
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("after_rst_fetch", 64'(pf), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
